// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one add-and-correct stage reused per digit, LSD first.
// Optional BCD_CHECK_EN flags operand digits above 9 on the err output.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  co,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t state, state_n;

    logic [4*DIGITS-1:0] a_r;
    logic [4*DIGITS-1:0] b_r;
    logic [4*DIGITS-1:0] res_r;
    logic [4*DIGITS-1:0] res_n;
    logic                carry;
    logic [IW-1:0]       idx;

    logic [3:0] a_d;
    logic [3:0] b_d;
    logic [4:0] s;
    logic [3:0] dig;
    logic       c_n;

    logic load;
    logic step;
    logic fin;

    // single digit stage
    always_comb begin
        a_d = a_r[idx*4 +: 4];
        b_d = b_r[idx*4 +: 4];
        s   = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
        dig = s[3:0];
        c_n = 1'b0;
        unique case (1'b1)
            (s > 5'd9): begin
                dig = s[3:0] + 4'd6;
                c_n = 1'b1;
            end
            default: begin
                dig = s[3:0];
                c_n = 1'b0;
            end
        endcase
        res_n = res_r;
        res_n[idx*4 +: 4] = dig;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (idx == LAST) begin
                    fin     = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (load) begin
                a_r   <= a;
                b_r   <= b;
                res_r <= '0;
                carry <= ci;
                idx   <= '0;
            end else if (step) begin
                res_r <= res_n;
                carry <= c_n;
                idx   <= idx + 1'b1;
            end
            if (fin) begin
                sum <= res_n;
                co  <= c_n;
            end
            busy <= (state_n == ADD);
            done <= (state_n == DONE);
        end
    end

`ifdef BCD_CHECK_EN
    logic bad;
    logic acc;
    logic err_r;

    assign bad = (a_d > 4'd9) || (b_d > 4'd9);
    assign err = err_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (load) begin
                acc <= 1'b0;
            end else if (step) begin
                acc <= acc | bad;
            end
            if (fin) begin
                err_r <= acc | bad;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl: random BCD operands against a
// decimal-arithmetic reference model, plus directed handshake/reset cases.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
    logic         err;

    int tests = 0;
    int fails = 0;

    exp_t exp_q[$];

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .a    (a),
        .b    (b),
        .ci   (ci),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .co   (co),
        .err  (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic c);
        exp_t r;
        logic bad;
        longint vx, vy, tot, pw;
        int dx, dy, t, cr;
        bad = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        r.s = '0;
        if (!bad) begin
            vx = 0;
            vy = 0;
            pw = 1;
            for (int i = D - 1; i >= 0; i--) begin
                vx = vx * 10 + longint'(x[4*i +: 4]);
                vy = vy * 10 + longint'(y[4*i +: 4]);
                pw = pw * 10;
            end
            tot = vx + vy + longint'(c);
            r.c = (tot >= pw);
            tot = tot % pw;
            for (int i = 0; i < D; i++) begin
                r.s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            cr = int'(c);
            for (int i = 0; i < D; i++) begin
                dx = int'(x[4*i +: 4]);
                dy = int'(y[4*i +: 4]);
                t = dx + dy + cr;
                if (t > 9) begin
                    r.s[4*i +: 4] = 4'((t + 6) % 16);
                    cr = 1;
                end else begin
                    r.s[4*i +: 4] = 4'(t);
                    cr = 0;
                end
            end
            r.c = cr[0];
        end
`ifdef BCD_CHECK_EN
        r.e = bad;
`else
        r.e = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy || done) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic wait_done;
        int n;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: done %b want 1", done);
        end
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input int hold);
        wait_idle();
        a = x;
        b = y;
        ci = c;
        start = 1'b1;
        exp_q.push_back(model(x, y, c));
        repeat (1 + hold) tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    function automatic logic [W-1:0] rnd_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) begin
            if (allow_bad && $urandom_range(0, 9) == 0)
                v[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // monitor: scoreboard pops on done; outputs must hold otherwise
    int           busy_run = 0;
    logic [W-1:0] last_s = '0;
    logic         last_c = 1'b0;
    logic         last_e = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done %b want 0", done);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", sum, e.s);
                    chk("co", W'(co), W'(e.c));
                    chk("err", W'(err), W'(e.e));
                    chk("latency", W'(busy_run), W'(D));
                end
                busy_run = 0;
            end else if (busy) begin
                chk("hold_sum", sum, last_s);
                chk("hold_flags", W'({co, err}), W'({last_c, last_e}));
            end
        end
        last_s = sum;
        last_c = co;
        last_e = err;
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_sum", sum, '0);
        chk("rst_flags", W'({co, err}), '0);
        reset = 1'b0;
        tick();

        issue(16'h1234, 16'h8766, 1'b0, 0);
        issue(16'h9999, 16'h0001, 1'b0, 0);
        issue(16'h0000, 16'h0000, 1'b1, 0);

        // start held and re-asserted in DONE: one pulse only
        issue(16'h0456, 16'h0123, 1'b0, 3);
        wait_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("no_requeue_busy", W'(busy), '0);
        chk("no_requeue_done", W'(done), '0);

        // abandon an op with reset
        issue(16'h5555, 16'h5555, 1'b0, 0);
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_sum", sum, '0);
        chk("abort_co", W'(co), '0);
        void'(exp_q.pop_back());
        tick();
        reset = 1'b0;
        tick();
        issue(16'h5555, 16'h5555, 1'b0, 0);

        issue(16'h000A, 16'h0000, 1'b0, 0);
        issue(16'h0011, 16'h0022, 1'b0, 0);
        issue(16'h9999, 16'h9999, 1'b1, 0);

        for (int i = 0; i < 60; i++) begin
            issue(rnd_bcd(1'b1), rnd_bcd(1'b1), 1'($urandom),
                  int'($urandom_range(0, 2)));
        end

        wait_idle();
        repeat (2) tick();
        chk("queue_empty", W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
